adc_seq_ctrl: RTL and testbench
===============================

ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 32: mux settle time in clocks, legal range 1..4095.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum wait for a conversion result in clocks, legal range 1..65535.
REQ-003 clk_i  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset_ni  in  1  reset, asynchronous, active-low.
REQ-005 enable_i  in  1  run request; level-sensitive.
REQ-006 ch_mask_i  in  4  channel enable mask; bit n enables channel n.
REQ-007 clear_i  in  1  one-cycle clear of the sticky flags.
REQ-008 mux_sel_o  out  2  analog mux channel select.
REQ-009 conv_start_o  out  1  one-cycle conversion start pulse to the SAR ADC.
REQ-010 conv_data_i  in  14  ADC result; valid only while conv_rdy_i=1.
REQ-011 conv_rdy_i  in  1  ADC result strobe, one cycle.
REQ-012 res_data_o  out  14  buffered result.
REQ-013 res_ch_o  out  2  channel tag of res_data_o.
REQ-014 res_valid_o  out  1  result buffer full.
REQ-015 res_ready_i  in  1  consumer accept.
REQ-016 overrun_o  out  1  sticky: a result was dropped.
REQ-017 timeout_o  out  1  sticky: a conversion timed out.

Function
REQ-018 FSM states SHALL be IDLE, SELECT, SETTLE, START and WAIT; an unreachable encoding SHALL return to IDLE.
REQ-019 IDLE: when enable_i=1 and ch_mask_i!=0, the FSM SHALL go to SELECT; otherwise it SHALL stay in IDLE.
REQ-020 SELECT: the FSM SHALL pick the next enabled channel in ascending order after last_ch, wrapping 3->0, using ch_mask_i sampled in this cycle.
REQ-021 SELECT: the FSM SHALL load mux_sel_o and last_ch with the chosen channel, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-022 SELECT with ch_mask_i=0 SHALL go to IDLE with mux_sel_o unchanged.
REQ-023 SETTLE: the FSM SHALL go to START when the counter is 0, else decrement the counter.
REQ-024 With SELECT in cycle N, SETTLE SHALL occupy cycles N+1..N+SETTLE_CYCLES.
REQ-025 START: conv_start_o SHALL be 1 for exactly this one cycle; the timeout counter SHALL load TIMEOUT_CYCLES-1; the FSM SHALL go to WAIT.
REQ-026 WAIT with conv_rdy_i=1: the FSM SHALL capture conv_data_i with the mux_sel_o tag.
REQ-027 WAIT with conv_rdy_i=0 and counter 0: the FSM SHALL set timeout_o, produce no result, and leave WAIT.
REQ-028 WAIT with conv_rdy_i=0 and counter nonzero: the FSM SHALL decrement the counter.
REQ-029 On leaving WAIT, the FSM SHALL go to SELECT if enable_i=1, else to IDLE.
REQ-030 conv_rdy_i outside WAIT SHALL be ignored.
REQ-031 Deasserting enable_i mid-sequence SHALL NOT abort; the current channel completes, then the FSM returns to IDLE.
REQ-032 mux_sel_o SHALL change only in SELECT.
REQ-033 Buffer load, capture with res_valid_o=0: res_data_o and res_ch_o SHALL load, and res_valid_o SHALL be 1 from the next cycle.
REQ-034 Buffer accept: res_valid_o=1 with res_ready_i=1 and no capture SHALL clear res_valid_o next cycle.
REQ-035 Simultaneous accept and capture SHALL load the new result, keep res_valid_o=1, and leave overrun_o unset.
REQ-036 Capture with res_valid_o=1 and res_ready_i=0 SHALL drop the new result, keep the old result, and set overrun_o.
REQ-037 clear_i=1 SHALL clear overrun_o and timeout_o next cycle; a set event in the same cycle SHALL win.
REQ-038 res_data_o and res_ch_o SHALL hold when res_valid_o=0.

Reset
REQ-039 Asynchronous reset SHALL force: state IDLE, last_ch=3 (first pick is ch0), mux_sel_o=0, conv_start_o=0, res_data_o=0, res_ch_o=0, res_valid_o=0, overrun_o=0, timeout_o=0, counters 0.
REQ-040 Reset in any state, including WAIT, SHALL abandon the conversion immediately; a conv_rdy_i arriving after release SHALL be ignored.

Verification
REQ-041 Round robin: mask=4'b1011, enable held, ADC answers 10 cycles after start, res_ready_i=1 -> channel order 0,1,3,0,1,3; starts spaced SETTLE_CYCLES+13 clocks apart.
REQ-042 Settle timing: SELECT at cycle 100, SETTLE_CYCLES=32 -> conv_start_o high only at cycle 133; mux_sel_o stable over cycles 101..133.
REQ-043 Timeout: TIMEOUT_CYCLES=16, conv_rdy_i never asserted -> timeout_o set 16 cycles after start; next channel selected; res_valid_o stays 0.
REQ-044 Overrun: res_ready_i=0, two conversions 0x1234 (ch0) then 0x0ABC (ch1) -> res_data_o=0x1234, res_ch_o=0, overrun_o=1.
REQ-045 Simultaneous accept and capture: res_ready_i=1 in the capture cycle -> new value presented; res_valid_o stays 1; overrun_o=0.
REQ-046 enable_i dropped during SETTLE -> one conversion completes and its result is delivered, then IDLE; no further conv_start_o.

Source files
------------

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: round-robin sequencer for a 4-channel analog mux feeding a SAR ADC.
// Each enabled channel is selected, allowed to settle, converted, and the result is
// placed in a one-entry output buffer with sticky overrun and timeout flags.
module adc_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  input  logic [3:0]  ch_mask_i,
  input  logic        clear_i,
  output logic [1:0]  mux_sel_o,
  output logic        conv_start_o,
  input  logic [13:0] conv_data_i,
  input  logic        conv_rdy_i,
  output logic [13:0] res_data_o,
  output logic [1:0]  res_ch_o,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic        overrun_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SETTLE = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  localparam logic [11:0] SETTLE_LOAD  = 12'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);

  // Next enabled channel after 'last' in ascending order with wrap 3->0.
  // Bit 2 of the result flags that some channel was enabled at all.
  function automatic logic [2:0] next_ch(input logic [1:0] last, input logic [3:0] mask);
    logic [1:0] cand;
    next_ch = 3'b000;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (mask[cand]) begin
        next_ch = {1'b1, cand};
      end
    end
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_last_ch;
  logic [1:0]  w_last_ch_nxt;
  logic [1:0]  r_mux_sel;
  logic [1:0]  w_mux_sel_nxt;
  logic [11:0] r_settle_cnt;
  logic [11:0] w_settle_cnt_nxt;
  logic [15:0] r_tmo_cnt;
  logic [15:0] w_tmo_cnt_nxt;
  logic        r_conv_start;
  logic [13:0] r_res_data;
  logic [1:0]  r_res_ch;
  logic        r_res_valid;
  logic        r_overrun;
  logic        r_timeout;
  logic        w_capture;
  logic        w_tmo_evt;
  logic        w_ovr_evt;
  logic        w_buf_load;
  logic [2:0]  w_pick;

  assign w_pick = next_ch(r_last_ch, ch_mask_i);

  // Next-state, channel selection and settle/timeout counter updates.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_ch_nxt    = r_last_ch;
    w_mux_sel_nxt    = r_mux_sel;
    w_settle_cnt_nxt = r_settle_cnt;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_capture        = 1'b0;
    w_tmo_evt        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_i && (ch_mask_i != 4'b0000)) begin
          w_state_nxt = S_SELECT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SELECT: begin
        if (w_pick[2]) begin
          w_mux_sel_nxt    = w_pick[1:0];
          w_last_ch_nxt    = w_pick[1:0];
          w_settle_cnt_nxt = SETTLE_LOAD;
          w_state_nxt      = S_SETTLE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == 12'd0) begin
          w_state_nxt = S_START;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt - 12'd1;
        end
      end
      S_START: begin
        w_tmo_cnt_nxt = TIMEOUT_LOAD;
        w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (conv_rdy_i) begin
          w_capture   = 1'b1;
          w_state_nxt = enable_i ? S_SELECT : S_IDLE;
        end else if (r_tmo_cnt == 16'd0) begin
          w_tmo_evt   = 1'b1;
          w_state_nxt = enable_i ? S_SELECT : S_IDLE;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A capture loads the buffer when it is empty or being drained this cycle;
  // otherwise the new result is dropped and flagged.
  assign w_buf_load = w_capture && (!r_res_valid || res_ready_i);
  assign w_ovr_evt  = w_capture && r_res_valid && !res_ready_i;

  // Sequencer state, channel registers, counters and the registered start pulse.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state      <= S_IDLE;
      r_last_ch    <= 2'd3;
      r_mux_sel    <= 2'd0;
      r_settle_cnt <= 12'd0;
      r_tmo_cnt    <= 16'd0;
      r_conv_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_ch    <= w_last_ch_nxt;
      r_mux_sel    <= w_mux_sel_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_conv_start <= (w_state_nxt == S_START);
    end
  end

  // One-entry result buffer; data and tag hold whenever nothing is loaded.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_res_data  <= 14'd0;
      r_res_ch    <= 2'd0;
      r_res_valid <= 1'b0;
    end else if (w_buf_load) begin
      r_res_data  <= conv_data_i;
      r_res_ch    <= r_mux_sel;
      r_res_valid <= 1'b1;
    end else if (r_res_valid && res_ready_i && !w_capture) begin
      r_res_valid <= 1'b0;
    end
  end

  // Sticky error flags; a set event in the same cycle as clear_i wins.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_overrun <= w_ovr_evt | (r_overrun & ~clear_i);
      r_timeout <= w_tmo_evt | (r_timeout & ~clear_i);
    end
  end

  assign mux_sel_o    = r_mux_sel;
  assign conv_start_o = r_conv_start;
  assign res_data_o   = r_res_data;
  assign res_ch_o     = r_res_ch;
  assign res_valid_o  = r_res_valid;
  assign overrun_o    = r_overrun;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: directed scenarios plus randomized traffic for adc_seq_ctrl,
// checked every cycle against a timestamp-based reference model.
module tb_adc_seq_ctrl;

  localparam int S = 32;
  localparam int T = 16;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic [3:0]  ch_mask_i = 4'b0000;
  logic        clear_i = 1'b0;
  logic [1:0]  mux_sel_o;
  logic        conv_start_o;
  logic [13:0] conv_data_i = 14'd0;
  logic        conv_rdy_i = 1'b0;
  logic [13:0] res_data_o;
  logic [1:0]  res_ch_o;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic        overrun_o;
  logic        timeout_o;

  adc_seq_ctrl #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(enable_i), .ch_mask_i(ch_mask_i),
    .clear_i(clear_i), .mux_sel_o(mux_sel_o), .conv_start_o(conv_start_o),
    .conv_data_i(conv_data_i), .conv_rdy_i(conv_rdy_i), .res_data_o(res_data_o),
    .res_ch_o(res_ch_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // stimulus knobs
  bit          k_en = 1'b0;
  logic [3:0]  k_mask = 4'b0000;
  int          k_ready = 0;     // 0: never, 1: always, 2: random, 3: only with conv_rdy_i
  int          k_lat = 0;       // ADC answer cycle offset from start; 0 = never answers
  bit          k_fixdata = 1'b0;
  bit          k_spur = 1'b0;
  bit          k_clr = 1'b0;
  bit          k_clr_once = 1'b0;
  bit          k_force_rdy = 1'b0;
  bit          k_rand = 1'b0;

  // reference model: conversions tracked by the cycles at which things happen
  int          m_sel_at;
  int          m_start_at;
  logic [1:0]  m_last;
  logic [1:0]  m_mux;
  logic [13:0] m_data;
  logic [1:0]  m_ch;
  logic        m_valid;
  logic        m_ovr;
  logic        m_tmo;

  int          starts_cyc[$];
  logic [1:0]  starts_ch[$];
  logic [13:0] last_rdy_data = 14'd0;
  logic [1:0]  rr_exp [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] last, input logic [3:0] msk);
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (int'(last) + k) % 4;
      if (msk[c]) return 2'(c);
    end
    return last;
  endfunction

  task automatic model_init();
    m_sel_at = -1; m_start_at = -1; m_last = 2'd3; m_mux = 2'd0;
    m_data = 14'd0; m_ch = 2'd0; m_valid = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic check_outputs();
    chk("mux_sel", 32'(mux_sel_o), 32'(m_mux));
    chk("conv_start", 32'(conv_start_o), 32'(m_start_at == cyc));
    chk("res_valid", 32'(res_valid_o), 32'(m_valid));
    chk("res_data", 32'(res_data_o), 32'(m_data));
    chk("res_ch", 32'(res_ch_o), 32'(m_ch));
    chk("overrun", 32'(overrun_o), 32'(m_ovr));
    chk("timeout", 32'(timeout_o), 32'(m_tmo));
  endtask

  // Apply this cycle's inputs to the model; results show up from the next cycle.
  task automatic model_update();
    bit cap = 1'b0, tmo = 1'b0, fin = 1'b0, ovr = 1'b0;
    if (m_start_at >= 0 && cyc > m_start_at) begin
      if (conv_rdy_i) begin cap = 1'b1; fin = 1'b1; end
      else if (cyc == m_start_at + T) begin tmo = 1'b1; fin = 1'b1; end
    end
    if (cap) begin
      if (!m_valid || res_ready_i) begin m_data = conv_data_i; m_ch = m_mux; m_valid = 1'b1; end
      else ovr = 1'b1;
    end else if (m_valid && res_ready_i) m_valid = 1'b0;
    if (clear_i) begin m_ovr = 1'b0; m_tmo = 1'b0; end
    if (ovr) m_ovr = 1'b1;
    if (tmo) m_tmo = 1'b1;
    if (m_sel_at == cyc) begin
      m_sel_at = -1;
      if (ch_mask_i != 4'b0000) begin
        m_mux = pick(m_last, ch_mask_i); m_last = m_mux; m_start_at = cyc + S + 1;
      end
    end else if (fin) begin
      m_start_at = -1;
      if (enable_i) m_sel_at = cyc + 1;
    end else if (m_start_at < 0 && m_sel_at < 0 && enable_i && ch_mask_i != 4'b0000) begin
      m_sel_at = cyc + 1;
    end
  endtask

  task automatic drive();
    if (k_rand) begin
      if ($urandom_range(0, 39) == 0) k_en = ~k_en;
      if ($urandom_range(0, 59) == 0) k_mask = 4'($urandom_range(0, 15));
      if (cyc == m_start_at + 1) k_lat = $urandom_range(1, 20);
    end
    enable_i = k_en;
    ch_mask_i = k_mask;
    conv_data_i = k_fixdata ? ((m_mux == 2'd0) ? 14'h1234 : 14'h0ABC) : 14'($urandom);
    conv_rdy_i = ((m_start_at >= 0) && (k_lat > 0) && (cyc == m_start_at + k_lat)) ||
                 k_force_rdy || (k_spur && ($urandom_range(0, 31) == 0));
    k_force_rdy = 1'b0;
    case (k_ready)
      0: res_ready_i = 1'b0;
      1: res_ready_i = 1'b1;
      2: res_ready_i = 1'($urandom_range(0, 1));
      default: res_ready_i = conv_rdy_i;
    endcase
    clear_i = k_clr_once || (k_clr && ($urandom_range(0, 15) == 0));
    k_clr_once = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    cyc++;
    #1;
    reset_ni = 1'b1;
    drive();
    @(negedge clk_i);
    check_outputs();
    if (conv_start_o) begin starts_cyc.push_back(cyc); starts_ch.push_back(mux_sel_o); end
    if (conv_rdy_i) last_rdy_data = conv_data_i;
    model_update();
  endtask

  // Assert reset mid-cycle; it is released just after the next rising edge.
  task automatic do_reset();
    reset_ni = 1'b0;
    #1;
    model_init();
    check_outputs();
  endtask

  task automatic wait_start(input int budget, output int sc);
    sc = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (conv_start_o) begin sc = cyc; break; end
    end
    if (sc < 0) chk("start_seen", 32'd0, 32'd1);
  endtask

  initial begin
    int s;
    int nexp;
    #2;
    do_reset();

    // round robin over mask 1011, ADC answers 10 cycles after it samples the start
    k_en = 1'b1; k_mask = 4'b1011; k_ready = 1; k_lat = 11;
    starts_cyc.delete(); starts_ch.delete();
    repeat (300) step();
    chk("rr_count", 32'(starts_cyc.size() >= 6), 32'd1);
    nexp = (starts_cyc.size() < 6) ? starts_cyc.size() : 6;
    if (nexp > 0) chk("settle_start", 32'(starts_cyc[0]), 32'd35);
    for (int i = 0; i < nexp; i++) chk("rr_ch", 32'(starts_ch[i]), 32'(rr_exp[i]));
    for (int i = 1; i < nexp; i++) chk("rr_space", 32'(starts_cyc[i] - starts_cyc[i-1]), 32'(S + 13));
    k_en = 1'b0;
    repeat (80) step();

    // timeout: ADC never answers
    k_lat = 0; k_mask = 4'b0110; k_en = 1'b1;
    wait_start(100, s);
    repeat (T + 1) step();
    chk("tmo_set", 32'(timeout_o), 32'd1);
    chk("tmo_novalid", 32'(res_valid_o), 32'd0);
    step();
    chk("tmo_next", 32'(mux_sel_o), (s >= 0 && starts_ch[$] == 2'd1) ? 32'd2 : 32'd1);
    k_en = 1'b0;
    repeat (60) step();
    k_clr_once = 1'b1;
    step(); step();
    chk("clr_tmo", 32'(timeout_o), 32'd0);

    // overrun: two results with no consumer
    do_reset();
    k_ready = 0; k_mask = 4'b0011; k_lat = 11; k_fixdata = 1'b1; k_en = 1'b1;
    wait_start(60, s);
    wait_start(80, s);
    k_en = 1'b0;
    repeat (20) step();
    chk("ovr_data", 32'(res_data_o), 32'h1234);
    chk("ovr_ch", 32'(res_ch_o), 32'd0);
    chk("ovr_flag", 32'(overrun_o), 32'd1);
    chk("ovr_valid", 32'(res_valid_o), 32'd1);

    // simultaneous accept and capture
    k_fixdata = 1'b0; k_clr_once = 1'b1;
    step(); step();
    chk("ovr_clr", 32'(overrun_o), 32'd0);
    k_ready = 3; k_mask = 4'b0001; k_en = 1'b1;
    wait_start(80, s);
    k_en = 1'b0;
    repeat (15) step();
    chk("sim_valid", 32'(res_valid_o), 32'd1);
    chk("sim_data", 32'(res_data_o), 32'(last_rdy_data));
    chk("sim_ch", 32'(res_ch_o), 32'd0);
    chk("sim_ovr", 32'(overrun_o), 32'd0);

    // enable dropped during settle: one conversion completes, then idle
    k_ready = 1;
    repeat (3) step();
    k_ready = 0; k_mask = 4'b1000; k_en = 1'b1;
    starts_cyc.delete(); starts_ch.delete();
    repeat (5) step();
    k_en = 1'b0;
    repeat (100) step();
    chk("drop_starts", 32'(starts_cyc.size()), 32'd1);
    chk("drop_valid", 32'(res_valid_o), 32'd1);
    chk("drop_ch", 32'(res_ch_o), 32'd3);

    // reset during WAIT, then a late ADC strobe
    k_ready = 1; k_lat = 0; k_mask = 4'b0001; k_en = 1'b1;
    wait_start(80, s);
    repeat (3) step();
    do_reset();
    k_en = 1'b0; k_force_rdy = 1'b1;
    starts_cyc.delete(); starts_ch.delete();
    repeat (40) step();
    chk("rst_valid", 32'(res_valid_o), 32'd0);
    chk("rst_starts", 32'(starts_cyc.size()), 32'd0);

    // randomized traffic
    do_reset();
    k_rand = 1'b1; k_ready = 2; k_clr = 1'b1; k_spur = 1'b1;
    k_en = 1'b1; k_mask = 4'b1111; k_lat = 11;
    repeat (6000) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
